sample_envelope: RTL and testbench

SAMPLE_ENVELOPE -- requirements
Module: sample_envelope

---
 rtl/sample_envelope.sv | 164 ++++++++++++++++
 tb/tb_sample_envelope.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_envelope.sv
// sample_envelope: ADSR gain generator applied to a strobed signed sample
// stream. Envelope state and gain advance once per input strobe; the sample
// is multiplied by the gain held before that strobe's update and leaves two
// cycles after the strobe.
module sample_envelope #(
    parameter int SAMPLE_WIDTH = 12,
    parameter int ENV_WIDTH    = 16
) (
    input  logic                           inCLK_50MHZ,
    input  logic                           inRESET_N,
    input  logic signed [SAMPLE_WIDTH-1:0] inSample,
    input  logic                           inSampleReady,
    input  logic                           inGate,
    input  logic        [ENV_WIDTH-1:0]    inAttackStep,
    input  logic        [ENV_WIDTH-1:0]    inDecayStep,
    input  logic        [ENV_WIDTH-1:0]    inReleaseStep,
    input  logic        [ENV_WIDTH-1:0]    inSustainLevel,
    output logic signed [SAMPLE_WIDTH-1:0] outSample,
    output logic                           outSampleReady,
    output logic        [ENV_WIDTH-1:0]    outEnvelope,
    output logic        [2:0]              outState,
    output logic                           outActive
);

    localparam int PROD_WIDTH = SAMPLE_WIDTH + ENV_WIDTH + 1;
    localparam logic [ENV_WIDTH-1:0] GAIN_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    env_state_t           state;
    env_state_t           state_next;
    logic [ENV_WIDTH-1:0] gain;
    logic [ENV_WIDTH-1:0] gain_next;

    // One extra bit so the attack overshoot and the decay floor cannot wrap.
    logic [ENV_WIDTH:0]   attack_sum;
    logic [ENV_WIDTH:0]   decay_floor;

    logic [PROD_WIDTH-1:0] sample_ext;
    logic [PROD_WIDTH-1:0] gain_ext;
    logic [PROD_WIDTH-1:0] product;
    logic [PROD_WIDTH-1:0] product_reg;
    logic                  product_valid;
    logic                  unused_product_bits;

    assign attack_sum  = {1'b0, gain} + {1'b0, inAttackStep};
    assign decay_floor = {1'b0, inSustainLevel} + {1'b0, inDecayStep};

    // Sign-extend the sample and zero-extend the gain to full product width,
    // so a plain modular multiply yields the exact signed product.
    assign sample_ext = {{(PROD_WIDTH-SAMPLE_WIDTH){inSample[SAMPLE_WIDTH-1]}}, inSample};
    assign gain_ext   = {{(PROD_WIDTH-ENV_WIDTH){1'b0}}, gain};
    assign product    = sample_ext * gain_ext;

    // Bits dropped by the shift-and-truncate; the top bit is a pure sign copy.
    assign unused_product_bits = ^{product_reg[PROD_WIDTH-1], product_reg[ENV_WIDTH-1:0]};

    // Next envelope state and gain; a gate change only switches phase and keeps
    // the gain, and a zero step finishes its phase on the spot.
    always_comb begin
        state_next = state;
        gain_next  = gain;
        if (inSampleReady) begin
            case (state)
                ST_IDLE: begin
                    if (inGate) begin
                        state_next = ST_ATTACK;
                    end else begin
                        gain_next = '0;
                    end
                end
                ST_ATTACK: begin
                    if (!inGate) begin
                        state_next = ST_RELEASE;
                    end else if ((inAttackStep == '0) || (attack_sum >= {1'b0, GAIN_MAX})) begin
                        gain_next  = GAIN_MAX;
                        state_next = ST_DECAY;
                    end else begin
                        gain_next = attack_sum[ENV_WIDTH-1:0];
                    end
                end
                ST_DECAY: begin
                    if (!inGate) begin
                        state_next = ST_RELEASE;
                    end else if ((inDecayStep == '0) || ({1'b0, gain} <= decay_floor)) begin
                        gain_next  = inSustainLevel;
                        state_next = ST_SUSTAIN;
                    end else begin
                        gain_next = gain - inDecayStep;
                    end
                end
                ST_SUSTAIN: begin
                    if (!inGate) begin
                        state_next = ST_RELEASE;
                    end else begin
                        gain_next = inSustainLevel;
                    end
                end
                ST_RELEASE: begin
                    if (inGate) begin
                        state_next = ST_ATTACK;
                    end else if ((inReleaseStep == '0) || (gain <= inReleaseStep)) begin
                        gain_next  = '0;
                        state_next = ST_IDLE;
                    end else begin
                        gain_next = gain - inReleaseStep;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    gain_next  = '0;
                end
            endcase
        end
    end

    // Envelope state and gain registers.
    always_ff @(posedge inCLK_50MHZ) begin
        if (!inRESET_N) begin
            state <= ST_IDLE;
            gain  <= '0;
        end else begin
            state <= state_next;
            gain  <= gain_next;
        end
    end

    // First pipeline stage: capture the product made with the pre-update gain.
    always_ff @(posedge inCLK_50MHZ) begin
        if (!inRESET_N) begin
            product_reg   <= '0;
            product_valid <= 1'b0;
        end else begin
            product_valid <= inSampleReady;
            if (inSampleReady) begin
                product_reg <= product;
            end
        end
    end

    // Second pipeline stage: scale back to sample width and hold between strobes.
    always_ff @(posedge inCLK_50MHZ) begin
        if (!inRESET_N) begin
            outSample      <= '0;
            outSampleReady <= 1'b0;
        end else begin
            outSampleReady <= product_valid;
            if (product_valid) begin
                outSample <= product_reg[ENV_WIDTH+SAMPLE_WIDTH-1:ENV_WIDTH];
            end
        end
    end

    assign outEnvelope = gain;
    assign outState    = state;
    assign outActive   = (state != ST_IDLE);

endmodule

// File: tb/tb_sample_envelope.sv
// tb_sample_envelope: directed ADSR scenarios against an arithmetic model of
// the envelope rules and the two-cycle sample pipeline.
module tb_sample_envelope;

    localparam int GMAX = 65535;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [11:0] in_sample;
    logic               in_ready;
    logic               in_gate;
    logic [15:0]        atk, dec, rel, sus;

    logic signed [11:0] out_sample;
    logic               out_ready;
    logic [15:0]        out_env;
    logic [2:0]         out_state;
    logic               out_active;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // Model state: phase number, gain as an integer, and the two pipeline stages.
    int         m_state = 0;
    int         m_gain = 0;
    bit         s1_valid = 1'b0;
    logic [11:0] s1_val = '0;
    bit         m_ready = 1'b0;
    logic [11:0] m_out = '0;

    logic [11:0] tbl [8] = '{12'h7FF, 12'h800, 12'h001, 12'hFFF,
                             12'h400, 12'hC00, 12'h123, 12'hEDC};
    int exp_gain [4];

    sample_envelope #(.SAMPLE_WIDTH(12), .ENV_WIDTH(16)) dut (
        .inCLK_50MHZ    (clk),
        .inRESET_N      (rst_n),
        .inSample       (in_sample),
        .inSampleReady  (in_ready),
        .inGate         (in_gate),
        .inAttackStep   (atk),
        .inDecayStep    (dec),
        .inReleaseStep  (rel),
        .inSustainLevel (sus),
        .outSample      (out_sample),
        .outSampleReady (out_ready),
        .outEnvelope    (out_env),
        .outState       (out_state),
        .outActive      (out_active)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Scaled sample: floor(sample * gain / 65536), kept to 12 bits.
    function automatic logic [11:0] expectedSample(input logic signed [11:0] s, input int g);
        int p;
        p = int'(s) * g;
        p = p >>> 16;
        return p[11:0];
    endfunction

    // Count one comparison and report it when the values differ.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one strobe for a single cycle; returns after the edge that consumed it.
    task automatic applyStimulus(input logic [11:0] s, input logic g);
        @(negedge clk);
        in_sample = s;
        in_gate   = g;
        in_ready  = 1'b1;
        @(negedge clk);
        in_ready  = 1'b0;
    endtask

    // Reference model advanced on each rising edge from the envelope rules.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_state  = 0;
            m_gain   = 0;
            s1_valid = 1'b0;
            m_ready  = 1'b0;
            m_out    = '0;
        end else begin
            m_ready = s1_valid;
            if (s1_valid) m_out = s1_val;
            s1_valid = in_ready;
            if (in_ready) begin
                s1_val = expectedSample(in_sample, m_gain);
                case (m_state)
                    0: if (in_gate) m_state = 1; else m_gain = 0;
                    1: if (!in_gate) m_state = 4;
                       else if (atk == 0 || m_gain + int'(atk) >= GMAX) begin m_gain = GMAX; m_state = 2; end
                       else m_gain = m_gain + int'(atk);
                    2: if (!in_gate) m_state = 4;
                       else if (dec == 0 || m_gain <= int'(sus) + int'(dec)) begin m_gain = int'(sus); m_state = 3; end
                       else m_gain = m_gain - int'(dec);
                    3: if (!in_gate) m_state = 4; else m_gain = int'(sus);
                    default: if (in_gate) m_state = 1;
                       else if (rel == 0 || m_gain <= int'(rel)) begin m_gain = 0; m_state = 0; end
                       else m_gain = m_gain - int'(rel);
                endcase
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model_envelope", int'(out_env), m_gain);
            checkOutput("model_state", int'(out_state), m_state);
            checkOutput("model_active", int'(out_active), int'(m_state != 0));
            checkOutput("model_ready", int'(out_ready), int'(m_ready));
            checkOutput("model_sample", int'(unsigned'(out_sample)), int'(m_out));
        end
    end

    // Directed scenario sequence.
    initial begin
        rst_n = 1'b0; in_ready = 1'b0; in_gate = 1'b0; in_sample = '0;
        atk = 16'h4000; dec = 16'h2000; sus = 16'h8000; rel = 16'h3000;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        checkOutput("reset_envelope", int'(out_env), 0);
        checkOutput("reset_state", int'(out_state), 0);
        checkOutput("reset_ready", int'(out_ready), 0);
        checkOutput("reset_sample", int'(unsigned'(out_sample)), 0);
        checkOutput("reset_active", int'(out_active), 0);
        rst_n = 1'b1;

        // Gate low: full-scale sample comes out silent, two cycles after its strobe.
        applyStimulus(12'h7FF, 1'b0);
        checkOutput("idle_ready_t1", int'(out_ready), 0);
        @(negedge clk);
        checkOutput("idle_ready_t2", int'(out_ready), 1);
        checkOutput("idle_sample", int'(unsigned'(out_sample)), 0);
        @(negedge clk);
        checkOutput("idle_ready_t3", int'(out_ready), 0);
        checkOutput("idle_state", int'(out_state), 0);

        // Attack ramp with clamp.
        applyStimulus(12'h100, 1'b1);
        checkOutput("attack_enter_state", int'(out_state), 1);
        checkOutput("attack_enter_gain", int'(out_env), 0);
        exp_gain = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(12'h100, 1'b1);
            checkOutput("attack_gain", int'(out_env), exp_gain[i]);
        end
        checkOutput("attack_to_decay", int'(out_state), 2);

        // Decay to sustain.
        exp_gain = '{16'hDFFF, 16'hBFFF, 16'h9FFF, 16'h8000};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(12'h100, 1'b1);
            checkOutput("decay_gain", int'(out_env), exp_gain[i]);
        end
        checkOutput("decay_to_sustain", int'(out_state), 3);

        // Most negative sample at half gain.
        applyStimulus(12'h800, 1'b1);
        @(negedge clk);
        checkOutput("half_gain_ready", int'(out_ready), 1);
        checkOutput("half_gain_sample", int'(unsigned'(out_sample)), 12'hC00);

        // Release to idle.
        applyStimulus(12'h000, 1'b0);
        checkOutput("release_enter_state", int'(out_state), 4);
        checkOutput("release_enter_gain", int'(out_env), 16'h8000);
        checkOutput("release_active", int'(out_active), 1);
        exp_gain = '{16'h5000, 16'h2000, 16'h0000, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(12'h000, 1'b0);
            checkOutput("release_gain", int'(out_env), exp_gain[i]);
        end
        checkOutput("release_to_idle", int'(out_state), 0);
        checkOutput("idle_inactive", int'(out_active), 0);

        // Zero steps complete their phase at once; retrigger from release keeps gain.
        atk = 16'h0000; dec = 16'h0000;
        applyStimulus(12'h000, 1'b1);
        applyStimulus(12'h000, 1'b1);
        checkOutput("zero_attack_gain", int'(out_env), 16'hFFFF);
        applyStimulus(12'h000, 1'b1);
        checkOutput("zero_decay_gain", int'(out_env), 16'h8000);
        checkOutput("zero_decay_state", int'(out_state), 3);
        applyStimulus(12'h000, 1'b0);
        applyStimulus(12'h000, 1'b0);
        checkOutput("release_before_retrig", int'(out_env), 16'h5000);
        applyStimulus(12'h000, 1'b1);
        checkOutput("retrig_state", int'(out_state), 1);
        checkOutput("retrig_gain", int'(out_env), 16'h5000);
        applyStimulus(12'h000, 1'b1);
        checkOutput("retrig_zero_attack", int'(out_env), 16'hFFFF);
        checkOutput("retrig_decay_state", int'(out_state), 2);
        applyStimulus(12'h000, 1'b0);
        rel = 16'h0000;
        applyStimulus(12'h000, 1'b0);
        checkOutput("zero_release_gain", int'(out_env), 0);
        checkOutput("zero_release_state", int'(out_state), 0);

        // Back-to-back strobes, then reset in the following cycle with strobes held during reset.
        atk = 16'h6000; dec = 16'h3000; sus = 16'hA000; rel = 16'h3000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_sample = tbl[i];
            in_gate   = 1'b1;
            in_ready  = 1'b1;
        end
        @(negedge clk);
        in_ready = 1'b0;
        rst_n    = 1'b0;
        checkOutput("burst_gain", int'(out_env), 16'hA000);
        checkOutput("burst_state", int'(out_state), 3);
        checkOutput("burst_ready", int'(out_ready), 1);
        checkOutput("burst_sample", int'(unsigned'(out_sample)), 12'h0B5);
        @(negedge clk);
        in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post_reset_ready", int'(out_ready), 0);
            checkOutput("post_reset_sample", int'(unsigned'(out_sample)), 0);
            checkOutput("post_reset_gain", int'(out_env), 0);
        end

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
